corelet_seq: RTL and testbench

//  Instruction sequencer that drives the 35-bit corelet instruction word for one layer tile.

---
 rtl/corelet_seq.sv | 168 ++++++++++++++++
 tb/tb_corelet_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/corelet_seq.sv
// rtl/corelet_seq.sv - per-tile instruction sequencer for the corelet
// Walks weight fill, kernel load, gap, activation fill, execute and OFIFO drain for each kernel pass.
module corelet_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               cfg_mode,
  input  logic [cnt_bw-1:0]  cfg_nij,
  input  logic [cnt_bw-1:0]  cfg_nkij,
  input  logic [addr_bw-1:0] cfg_w_base,
  input  logic [addr_bw-1:0] cfg_a_base,
  input  logic [addr_bw-1:0] cfg_p_base,
  input  logic               ofifo_valid,
  output logic [34:0]        inst,
  output logic               busy,
  output logic               done
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LD, S_GAP, S_A_L0, S_EXEC, S_DRAIN, S_OUT, S_DONE
  } state_t;

  localparam logic [cnt_bw-1:0] col_c  = cnt_bw'(col);
  localparam logic [cnt_bw-1:0] col_m1 = cnt_bw'(col - 1);
  localparam logic [cnt_bw-1:0] row_m1 = cnt_bw'(row - 1);

  state_t               state_q, state_d;
  logic [cnt_bw-1:0]    k_q, k_d, i_q, i_d;
  logic                 rd_q, rd_d;
  logic                 mode_q, mode_d;
  logic [cnt_bw-1:0]    nij_q, nij_d, nkij_q, nkij_d;
  logic [addr_bw-1:0]   wb_q, wb_d, ab_q, ab_d, pb_q, pb_d;
  logic [34:0]          inst_q, inst_d;
  logic                 busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    rd_d    = 1'b0;
    mode_d  = mode_q;
    nij_d   = nij_q;
    nkij_d  = nkij_q;
    wb_d    = wb_q;
    ab_d    = ab_q;
    pb_d    = pb_q;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d  = cfg_mode;
        nij_d   = cfg_nij;
        nkij_d  = cfg_nkij;
        wb_d    = cfg_w_base;
        ab_d    = cfg_a_base;
        pb_d    = cfg_p_base;
        k_d     = '0;
        i_d     = '0;
        state_d = (cfg_nij == '0 || cfg_nkij == '0) ? S_DONE : S_W_L0;
      end
      S_W_L0: if (i_q == col_c) begin state_d = S_W_LD; i_d = '0; end
              else i_d = i_q + 1'b1;
      S_W_LD: if (i_q == col_m1) begin state_d = S_GAP; i_d = '0; end
              else i_d = i_q + 1'b1;
      S_GAP:  if (i_q == row_m1) begin state_d = S_A_L0; i_d = '0; end
              else i_d = i_q + 1'b1;
      S_A_L0: if (i_q == nij_q) begin state_d = S_EXEC; i_d = '0; end
              else i_d = i_q + 1'b1;
      S_EXEC: if (i_q == nij_q - 1'b1) begin state_d = S_DRAIN; i_d = '0; end
              else i_d = i_q + 1'b1;
      S_DRAIN: if (ofifo_valid) begin state_d = S_OUT; rd_d = 1'b1; i_d = cnt_bw'(1); end
      S_OUT: begin
        // i counts reads issued; the pass ends on the write cycle that follows the last read
        if (i_q == nij_q && !rd_q) begin
          k_d     = k_q + 1'b1;
          i_d     = '0;
          state_d = (k_d == nkij_q) ? S_DONE : S_W_L0;
        end else begin
          rd_d = ofifo_valid && (i_q != nij_q);
          i_d  = i_q + cnt_bw'(rd_d);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      i_d     = '0;
      rd_d    = 1'b0;
    end

    // Outputs are registered, so the word is built from the upcoming state and counters
    inst_d = '0;
    if (state_d != S_IDLE && state_d != S_DONE) inst_d[34] = mode_d;
    case (state_d)
      S_W_L0: begin
        if (i_d < col_c) begin
          inst_d[18]   = 1'b1;
          inst_d[17:7] = wb_d + addr_bw'(k_d) * addr_bw'(col) + addr_bw'(i_d);
        end
        inst_d[2] = (i_d != '0);
      end
      S_W_LD: begin inst_d[3] = 1'b1; inst_d[0] = 1'b1; end
      S_A_L0: begin
        if (i_d < nij_d) begin
          inst_d[18]   = 1'b1;
          inst_d[17:7] = ab_d + addr_bw'(i_d);
        end
        inst_d[2] = (i_d != '0);
      end
      S_EXEC: begin inst_d[3] = 1'b1; inst_d[1] = 1'b1; end
      S_OUT: begin
        inst_d[6] = rd_d;
        if (rd_q) begin
          inst_d[31]    = 1'b1;
          inst_d[32]    = 1'b1;
          inst_d[33]    = (k_q != '0);
          inst_d[30:20] = pb_q + addr_bw'(i_q) - addr_bw'(1);
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      i_q     <= '0;
      rd_q    <= 1'b0;
      mode_q  <= 1'b0;
      nij_q   <= '0;
      nkij_q  <= '0;
      wb_q    <= '0;
      ab_q    <= '0;
      pb_q    <= '0;
      inst_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      rd_q    <= rd_d;
      mode_q  <= mode_d;
      nij_q   <= nij_d;
      nkij_q  <= nkij_d;
      wb_q    <= wb_d;
      ab_q    <= ab_d;
      pb_q    <= pb_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_corelet_seq.sv
// tb/tb_corelet_seq.sv - bench for corelet_seq
// Expected instruction traces are generated per phase from the tile parameters and a valid pattern.
module tb_corelet_seq;

  localparam int COL = 8;
  localparam int ROW = 8;
  localparam logic [34:0] M_MODE = 35'h4_0000_0000;
  localparam logic [34:0] M_SFP  = 35'h2_0000_0000;
  localparam logic [34:0] M_PWE  = 35'h1_0000_0000;
  localparam logic [34:0] M_PEN  = 35'h0_8000_0000;
  localparam logic [34:0] M_XEN  = 35'h0_0004_0000;
  localparam logic [34:0] M_ORD  = 35'h40;
  localparam logic [34:0] M_L0RD = 35'h8;
  localparam logic [34:0] M_L0WR = 35'h4;
  localparam logic [34:0] M_EX   = 35'h2;
  localparam logic [34:0] M_KL   = 35'h1;

  typedef struct {
    int nij; int nkij; bit mode; int wb; int ab; int pb; int vmode; int exp_busy;
  } vec_t;

  logic clk = 1'b0, reset, start, abort, cfg_mode, ofifo_valid;
  logic [7:0]  cfg_nij, cfg_nkij;
  logic [10:0] cfg_w_base, cfg_a_base, cfg_p_base;
  logic [34:0] inst;
  logic        busy, done;

  int n_vec = 0, n_err = 0;
  logic [34:0] exp_q[$];
  bit vpat[4096];
  vec_t tbl[7];

  corelet_seq #(.row(ROW), .col(COL), .addr_bw(11), .cnt_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .cfg_nij(cfg_nij), .cfg_nkij(cfg_nkij), .cfg_w_base(cfg_w_base),
    .cfg_a_base(cfg_a_base), .cfg_p_base(cfg_p_base), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] xa(input int a);
    xa = 35'(a & 32'h7FF) << 7;
  endfunction

  function automatic logic [34:0] pa(input int a);
    pa = 35'(a & 32'h7FF) << 20;
  endfunction

  task automatic fill_vpat(input int vmode);
    for (int c = 0; c < 4096; c++)
      vpat[c] = (vmode == 0) ? 1'b1 : (vmode == 2) ? (c % 3 == 0) : ($urandom_range(0, 9) < 6);
  endtask

  task automatic build_model(input bit mode, input int nij, input int nkij,
                             input int wb, input int ab, input int pb);
    logic [34:0] m, w;
    int c, reads, pend;
    bit rd;
    exp_q.delete();
    m = mode ? M_MODE : '0;
    if (nij != 0 && nkij != 0) begin
      for (int k = 0; k < nkij; k++) begin
        for (int i = 0; i <= COL; i++) begin
          w = m;
          if (i < COL) w |= M_XEN | xa(wb + k * COL + i);
          if (i > 0) w |= M_L0WR;
          exp_q.push_back(w);
        end
        for (int i = 0; i < COL; i++) exp_q.push_back(m | M_L0RD | M_KL);
        for (int i = 0; i < ROW; i++) exp_q.push_back(m);
        for (int i = 0; i <= nij; i++) begin
          w = m;
          if (i < nij) w |= M_XEN | xa(ab + i);
          if (i > 0) w |= M_L0WR;
          exp_q.push_back(w);
        end
        for (int i = 0; i < nij; i++) exp_q.push_back(m | M_L0RD | M_EX);
        c = exp_q.size();
        do begin exp_q.push_back(m); c++; end while (!vpat[c-1]);
        reads = 0;
        pend  = -1;
        while (1) begin
          rd = (reads < nij) && vpat[c-1];
          w = m;
          if (rd) w |= M_ORD;
          if (pend >= 0) w |= M_PEN | M_PWE | pa(pb + pend) | ((k != 0) ? M_SFP : '0);
          exp_q.push_back(w);
          c++;
          pend = rd ? reads : -1;
          if (rd) reads++;
          else if (reads == nij) break;
        end
      end
    end
    exp_q.push_back('0);
  endtask

  task automatic run(input vec_t v, input bit stray);
    int busy_n, done_n, wr_n, last;
    busy_n = 0; done_n = 0; wr_n = 0;
    fill_vpat(v.vmode);
    build_model(v.mode, v.nij, v.nkij, v.wb, v.ab, v.pb);
    last = exp_q.size() - 1;
    cfg_mode = v.mode; cfg_nij = 8'(v.nij); cfg_nkij = 8'(v.nkij);
    cfg_w_base = 11'(v.wb); cfg_a_base = 11'(v.ab); cfg_p_base = 11'(v.pb);
    start = 1'b1; ofifo_valid = 1'b0;
    for (int c = 0; c <= last; c++) begin
      step();
      chk("inst", inst, exp_q[c]);
      chk("done", {34'b0, done}, {34'b0, c == last});
      if (busy) busy_n++;
      if (done) done_n++;
      if (inst[31]) wr_n++;
      start = stray && (c == 5);
      ofifo_valid = vpat[c];
    end
    step();
    start = 1'b0;
    ofifo_valid = 1'b0;
    chk("idle_busy", {34'b0, busy}, '0);
    chk("idle_inst", inst, '0);
    chk("done_count", 35'(done_n), 35'd1);
    chk("pmem_writes", 35'(wr_n), 35'((v.nij == 0 || v.nkij == 0) ? 0 : v.nij * v.nkij));
    if (v.exp_busy >= 0) chk("busy_cycles", 35'(busy_n), 35'(v.exp_busy));
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{4, 1, 1'b0, 'h10,  'h100, 'h200, 0, 41};
    tbl[1] = '{4, 3, 1'b0, 'h10,  'h100, 'h200, 0, 121};
    tbl[2] = '{0, 2, 1'b1, 'h20,  'h30,  'h40,  0, 1};
    tbl[3] = '{4, 1, 1'b0, 'h10,  'h100, 'h300, 2, 49};
    tbl[4] = '{5, 0, 1'b0, 'h10,  'h100, 'h200, 0, 1};
    tbl[5] = '{1, 2, 1'b1, 'h7FC, 'h7FF, 'h10,  0, 63};
    tbl[6] = '{3, 1, 1'b1, 'h55,  'h66,  'h7FE, 0, 38};

    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_mode = 1'b0; ofifo_valid = 1'b0;
    cfg_nij = '0; cfg_nkij = '0; cfg_w_base = '0; cfg_a_base = '0; cfg_p_base = '0;
    repeat (3) step();
    chk("rst_inst", inst, '0);
    chk("rst_busy", {34'b0, busy}, '0);
    chk("rst_done", {34'b0, done}, '0);
    reset = 1'b0;
    step();

    foreach (tbl[n]) run(tbl[n], n == 1);

    // reset held three cycles in the middle of EXEC
    cfg_mode = 1'b1; cfg_nij = 8'd20; cfg_nkij = 8'd1; start = 1'b1;
    step();
    start = 1'b0; ofifo_valid = 1'b1;
    repeat (50) step();
    chk("exec_seen", inst & (M_EX | M_MODE), M_EX | M_MODE);
    reset = 1'b1;
    repeat (3) begin
      step();
      chk("rst_mid_inst", inst, '0);
      chk("rst_mid_busy", {34'b0, busy}, '0);
    end
    reset = 1'b0;
    step();
    chk("post_rst_inst", inst, '0);
    chk("post_rst_busy", {34'b0, busy}, '0);
    ofifo_valid = 1'b0;

    // abort during kernel load, then a clean rerun
    cfg_mode = 1'b1; cfg_nij = 8'd4; cfg_nkij = 8'd1; cfg_w_base = 11'h10; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("wld_inst", inst, M_MODE | M_L0RD | M_KL);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_inst", inst, '0);
    chk("abort_busy", {34'b0, busy}, '0);
    chk("abort_done", {34'b0, done}, '0);
    step();
    chk("abort_no_done", {34'b0, done}, '0);

    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("abort_wins_busy", {34'b0, busy}, '0);
    step();
    chk("abort_wins_idle", {34'b0, busy}, '0);

    run(tbl[0], 1'b0);

    for (int r = 0; r < 20; r++) begin
      v.nij = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
      v.nkij = $urandom_range(0, 3);
      v.mode = 1'($urandom_range(0, 1));
      v.wb = $urandom_range(0, 2047);
      v.ab = $urandom_range(0, 2047);
      v.pb = $urandom_range(0, 2047);
      v.vmode = 1;
      v.exp_busy = -1;
      run(v, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
